// File: rtl/elgamal_mask.sv
// ElGamal ciphertext half c2 = (m * s) mod p using a bit-serial interleaved
// (Blakley) modular multiplier. It processes one multiplier bit per clock.
module elgamal_mask #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_secret_tdata,
    input  logic            input_secret_tvalid,
    output logic            input_secret_tready,
    input  logic [SIZE-1:0] input_message_tdata,
    input  logic            input_message_tvalid,
    output logic            input_message_tready,
    input  logic [SIZE-1:0] input_modulus_tdata,
    input  logic            input_modulus_tvalid,
    output logic            input_modulus_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
    input  logic            output_tready,
    output logic            output_tuser
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int XW = SIZE + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] r_q, r_d;
    logic [SIZE-1:0] s_q, s_d;
    logic [SIZE-1:0] m_q, m_d;
    logic [SIZE-1:0] p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tuser_q, tuser_d;

    logic            accept_s;
    logic            range_err_s;
    logic [XW-1:0]   addend_s;
    logic [XW-1:0]   pext_s;
    logic [XW-1:0]   t0_s;
    logic [XW-1:0]   t1_s;
    logic [XW-1:0]   t2_s;

    // The reset term keeps the shared ready low while reset is asserted, even when the sources are valid.
    assign accept_s = rst & (state_q == IDLE) & input_secret_tvalid
                      & input_message_tvalid & input_modulus_tvalid;

    assign input_secret_tready  = accept_s;
    assign input_message_tready = accept_s;
    assign input_modulus_tready = accept_s;

    assign range_err_s = (input_secret_tdata >= input_modulus_tdata) ||
                         (input_message_tdata >= input_modulus_tdata);

    // The bound 2R + s < 3p means that two conditional subtractions restore R < p.
    assign addend_s = m_q[cnt_q] ? {2'b00, s_q} : {XW{1'b0}};
    assign pext_s   = {2'b00, p_q};
    assign t0_s     = {1'b0, r_q, 1'b0} + addend_s;
    assign t1_s     = (t0_s >= pext_s) ? (t0_s - pext_s) : t0_s;
    assign t2_s     = (t1_s >= pext_s) ? (t1_s - pext_s) : t1_s;

    assign output_tvalid = (state_q == DONE);
    assign output_tdata  = r_q;
    assign output_tuser  = tuser_q;

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        tuser_d = tuser_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    s_d = input_secret_tdata;
                    m_d = input_message_tdata;
                    p_d = input_modulus_tdata;
                    r_d = {SIZE{1'b0}};
                    if (range_err_s) begin
                        tuser_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        tuser_d = 1'b0;
                        cnt_d   = CW'(SIZE - 1);
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                r_d = t2_s[SIZE-1:0];
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (output_tready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= {SIZE{1'b0}};
            s_q     <= {SIZE{1'b0}};
            m_q     <= {SIZE{1'b0}};
            p_q     <= {SIZE{1'b0}};
            cnt_q   <= {CW{1'b0}};
            tuser_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            tuser_q <= tuser_d;
        end
    end

endmodule

// File: doc/elgamal_mask.md
# elgamal_mask

Second-half ElGamal encryption stage: takes the shared secret `s = y^k mod p` from the modular exponentiator's output stream, plus a plaintext block `m` and the modulus `p`. It produces the ciphertext half `c2 = (m * s) mod p` on an AXI-stream output. It sits directly downstream of the exponentiator, whose output feeds `input_secret`. Multiplication is bit-serial interleaved (Blakley): one multiplier bit per clock, no DSP use.

## Interface
- SIZE, 64, operand/result width in bits.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_secret_tdata  in  SIZE  shared secret s.
- input_secret_tvalid  in  1  s valid.
- input_secret_tready  out  1  s accepted.
- input_message_tdata  in  SIZE  plaintext m.
- input_message_tvalid  in  1  m valid.
- input_message_tready  out  1  m accepted.
- input_modulus_tdata  in  SIZE  modulus p.
- input_modulus_tvalid  in  1  p valid.
- input_modulus_tready  out  1  p accepted.
- output_tdata  out  SIZE  c2 = (m*s) mod p.
- output_tvalid  out  1  result valid.
- output_tready  in  1  downstream accepts.
- output_tuser  out  1  1 = operand out of range; tdata is 0.

## Operation
- States:
  - IDLE: wait for all three inputs.
  - CALC: iterate over multiplier bits.
  - DONE: hold the result until the downstream handshake.
- Joint input handshake:
  - All three tready signals are the same signal: `(state==IDLE) & all three tvalid`.
  - All three operands are captured on the same edge, the accept edge E0. No partial capture.
- Range check at E0: if `s >= p` or `m >= p` (this covers `p == 0`):
  - Go straight to DONE with result 0 and tuser 1.
  - CALC is skipped.
- Otherwise at E0:
  - R <= 0, tuser <= 0, bit counter <= SIZE-1, state <= CALC.
- CALC, each edge, with SIZE+2-bit arithmetic:
  - t = 2R + (m[cnt] ? s : 0)
  - if t ≥ p then t -= p, applied twice
  - R <= t[SIZE-1:0]
- Invariant: R < p after every step, given m, s < p.
- On the edge that processes cnt==0, state <= DONE. Otherwise the counter decrements.
- DONE:
  - output_tvalid = 1, output_tdata = R, output_tuser held.
  - On `output_tready & output_tvalid`, state <= IDLE.
- output_tdata and output_tuser stay stable while tvalid is high and tready is low.
- Inputs presented during CALC or DONE are not accepted: tready stays 0, and the operands must be held by the upstream source.

## Timing
- Reset (rst low, asynchronous):
  - State returns to IDLE; R, counter and captured operands clear to 0.
  - All tready = 0, output_tvalid = 0, output_tdata = 0, output_tuser = 0.
  - These values hold immediately on assertion, including mid-CALC; the partial result is discarded.
- Normal latency: output_tvalid rises after the SIZE-th edge following E0, i.e. SIZE clocks after acceptance.
- Error latency: output_tvalid rises after E0 itself, i.e. 1 clock after acceptance.
- Output handshake on edge Ek returns the block to IDLE. The next accept is possible on edge Ek+1.
- Maximum throughput is one result per SIZE+2 clocks.
- No combinational path from any input tvalid to output_tvalid. The input tready signals depend combinationally on the input tvalids and on state only.
- p == 1: the range check passes only for s = m = 0, and the result is 0 after the full SIZE cycles.

## Test plan
- SIZE=8, p=23, s=9, m=5, all valid together → ready pulses for 1 cycle; 8 clocks later tvalid=1, tdata=22, tuser=0.
- SIZE=8, p=251, s=250, m=250 → tdata=1, tuser=0 (tests the double-subtract path near the modulus).
- SIZE=8, p=23, s=30, m=5 → tvalid one clock after accept, tdata=0, tuser=1. Repeat with p=0, s=0, m=0 → tuser=1.
- Staggered valids: s valid at cycle 0, m at cycle 3, p at cycle 5 → no tready before cycle 5; all three tready in cycle 5 only; result correct.
- Backpressure: output_tready low for 10 cycles after tvalid → tdata/tuser stable, new inputs held off (tready=0). Release → back in IDLE, the next operand set is accepted on the following edge.
- Async reset: assert rst low at CALC cycle 4 → tvalid/tdata/tready go to 0 immediately. Release, then present p=23, s=9, m=5 → 22 after the standard latency.
